// File: rtl/riscv_base_divider.sv
// 32-bit iterative divider for RISC-V DIV/DIVU/REM/REMU: restoring radix-2, one
// quotient bit per cycle, with single-cycle fast paths for divide-by-zero and signed overflow.
module riscv_base_divider (
    input  logic        clk_i,
    input  logic        rst_i,
    input  logic        start_i,
    input  logic [1:0]  op_i,
    input  logic [31:0] a_i,
    input  logic [31:0] b_i,
    output logic        busy_o,
    output logic        valid_o,
    output logic [31:0] result_o
);

    typedef enum logic [1:0] {IDLE, CALC, DONE} state_t;

    state_t      state_q, state_d;
    logic [4:0]  cnt_q, cnt_d;
    logic [31:0] dvd_q, dvd_d;      // dividend bits shift out MSB-first, quotient bits shift in
    logic [31:0] dvs_q, dvs_d;
    logic [32:0] rem_q, rem_d;
    logic        negq_q, negq_d;
    logic        negr_q, negr_d;
    logic        isrem_q, isrem_d;
    logic [31:0] result_q, result_d;

    logic        sgn, a_neg, b_neg, ge;
    logic [31:0] a_mag, b_mag, quo_nx, q_fin, r_fin;
    logic [32:0] rem_nx;
    logic [33:0] diff;

    always_comb begin
        sgn   = ~op_i[0];
        a_neg = sgn & a_i[31];
        b_neg = sgn & b_i[31];
        a_mag = a_neg ? (~a_i + 32'd1) : a_i;
        b_mag = b_neg ? (~b_i + 32'd1) : b_i;

        // Trial subtract of the divisor from the shifted partial remainder;
        // a borrow (bit 33 set) means the step restores.
        diff   = {rem_q, dvd_q[31]} - {2'b00, dvs_q};
        ge     = ~diff[33];
        rem_nx = ge ? diff[32:0] : {rem_q[31:0], dvd_q[31]};
        quo_nx = {dvd_q[30:0], ge};
        q_fin  = negq_q ? (~quo_nx + 32'd1) : quo_nx;
        r_fin  = negr_q ? (~rem_nx[31:0] + 32'd1) : rem_nx[31:0];
    end

    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        dvd_d    = dvd_q;
        dvs_d    = dvs_q;
        rem_d    = rem_q;
        negq_d   = negq_q;
        negr_d   = negr_q;
        isrem_d  = isrem_q;
        result_d = result_q;

        case (state_q)
            IDLE: begin
                if (start_i) begin
                    isrem_d = op_i[1];
                    negq_d  = a_neg ^ b_neg;
                    negr_d  = a_neg;
                    dvd_d   = a_mag;
                    dvs_d   = b_mag;
                    rem_d   = '0;
                    cnt_d   = '0;
                    if (b_i == 32'd0) begin
                        result_d = op_i[1] ? a_i : 32'hFFFF_FFFF;
                        state_d  = DONE;
                    end else if (sgn && a_i == 32'h8000_0000 && b_i == 32'hFFFF_FFFF) begin
                        result_d = op_i[1] ? 32'd0 : 32'h8000_0000;
                        state_d  = DONE;
                    end else begin
                        state_d = CALC;
                    end
                end
            end
            CALC: begin
                dvd_d = quo_nx;
                rem_d = rem_nx;
                cnt_d = cnt_q + 5'd1;
                if (cnt_q == 5'd31) begin
                    result_d = isrem_q ? r_fin : q_fin;
                    state_d  = DONE;
                end
            end
            DONE: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q  <= IDLE;
            cnt_q    <= '0;
            dvd_q    <= '0;
            dvs_q    <= '0;
            rem_q    <= '0;
            negq_q   <= 1'b0;
            negr_q   <= 1'b0;
            isrem_q  <= 1'b0;
            result_q <= '0;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            dvd_q    <= dvd_d;
            dvs_q    <= dvs_d;
            rem_q    <= rem_d;
            negq_q   <= negq_d;
            negr_q   <= negr_d;
            isrem_q  <= isrem_d;
            result_q <= result_d;
        end
    end

    assign busy_o   = (state_q != IDLE);
    assign valid_o  = (state_q == DONE);
    assign result_o = result_q;

endmodule
